// File: rtl/transaction_control_if.sv
// Bundle between transaction_control and its environment: main-control handshake,
// balance RAM port and animation handshake.
interface transaction_control_if #(
    parameter int DATA_W = 8
) ();
    logic              start_transaction;
    logic [DATA_W-1:0] amount;
    logic [3:0]        key;
    logic [DATA_W-1:0] mem_rdata;
    logic              anim_done;
    logic [1:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic              anim_start;
    logic              finished_transaction;
    logic              success;
    logic              error;

    modport master (
        output start_transaction, amount, key, mem_rdata, anim_done,
        input  mem_addr, mem_wdata, mem_wren, anim_start, finished_transaction, success, error
    );

    modport slave (
        input  start_transaction, amount, key, mem_rdata, anim_done,
        output mem_addr, mem_wdata, mem_wren, anim_start, finished_transaction, success, error
    );
endinterface

// File: rtl/transaction_control.sv
// Coin transfer sequencer: reads sender/receiver balances from a synchronous RAM,
// validates the transfer, writes both balances back and hands off to the animation.
module transaction_control #(
    parameter int DATA_W       = 8,
    parameter int ANIM_TIMEOUT = 50000000
) (
    input logic                  clock,
    input logic                  resetn,
    transaction_control_if.slave bus
);
    localparam int               CNT_W    = (ANIM_TIMEOUT > 1) ? $clog2(ANIM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, RD_SRC, CAP_SRC, CAP_DST, CHECK, WR_SRC, WR_DST, ANIM, DONE
    } state_e;

    state_e            state_q, state_d;
    logic              start_prev_q;
    logic [DATA_W-1:0] amt_q, amt_d;
    logic [3:0]        key_q, key_d;
    logic [DATA_W-1:0] src_bal_q, src_bal_d;
    logic [DATA_W-1:0] dst_bal_q, dst_bal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              success_q, success_d;
    logic              error_q, error_d;

    logic [1:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic              anim_start;
    logic              finished;

    // Extra bit catches receiver overflow past 2^DATA_W-1.
    logic [DATA_W:0]   dst_sum;
    logic              reject;

    assign dst_sum = {1'b0, dst_bal_q} + {1'b0, amt_q};
    assign reject  = (amt_q == '0) || (key_q[1:0] == key_q[3:2]) ||
                     (amt_q > src_bal_q) || dst_sum[DATA_W];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            amt_q        <= '0;
            key_q        <= '0;
            src_bal_q    <= '0;
            dst_bal_q    <= '0;
            cnt_q        <= '0;
            success_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= bus.start_transaction;
            amt_q        <= amt_d;
            key_q        <= key_d;
            src_bal_q    <= src_bal_d;
            dst_bal_q    <= dst_bal_d;
            cnt_q        <= cnt_d;
            success_q    <= success_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        amt_d      = amt_q;
        key_d      = key_q;
        src_bal_d  = src_bal_q;
        dst_bal_d  = dst_bal_q;
        cnt_d      = '0;
        success_d  = success_q;
        error_d    = error_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wren   = 1'b0;
        anim_start = 1'b0;
        finished   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_transaction && !start_prev_q) begin
                    amt_d     = bus.amount;
                    key_d     = bus.key;
                    success_d = 1'b0;
                    error_d   = 1'b0;
                    state_d   = RD_SRC;
                end
            end
            RD_SRC: begin
                mem_addr = key_q[1:0];
                state_d  = CAP_SRC;
            end
            CAP_SRC: begin
                src_bal_d = bus.mem_rdata;
                mem_addr  = key_q[3:2];
                state_d   = CAP_DST;
            end
            CAP_DST: begin
                dst_bal_d = bus.mem_rdata;
                state_d   = CHECK;
            end
            CHECK: begin
                if (reject) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WR_SRC;
                end
            end
            WR_SRC: begin
                mem_wren  = 1'b1;
                mem_addr  = key_q[1:0];
                mem_wdata = src_bal_q - amt_q;
                state_d   = WR_DST;
            end
            WR_DST: begin
                mem_wren  = 1'b1;
                mem_addr  = key_q[3:2];
                mem_wdata = dst_sum[DATA_W-1:0];
                success_d = 1'b1;
                state_d   = ANIM;
            end
            ANIM: begin
                // Counter is zero only on the entry cycle, so it doubles as the pulse gate.
                anim_start = (cnt_q == '0);
                cnt_d      = cnt_q + CNT_W'(1);
                if (bus.anim_done || cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                finished = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr             = mem_addr;
    assign bus.mem_wdata            = mem_wdata;
    assign bus.mem_wren             = mem_wren;
    assign bus.anim_start           = anim_start;
    assign bus.finished_transaction = finished;
    assign bus.success              = success_q;
    assign bus.error                = error_q;
endmodule
